keypad_debounce_encoder: RTL and testbench



---
 rtl/keypad_pkg.sv | 25 ++
 rtl/key_prio_enc.sv | 28 ++
 rtl/keypad_debounce_encoder.sv | 186 ++++++++++++++++++
 tb/tb_keypad_debounce_encoder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the keypad debounce encoder:
//   - state_e    : debounce FSM state encoding
//   - code_width : width of a binary key code for n keys
//   - max3       : largest of three values, used to size the counters
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  function automatic int code_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_prio_enc.sv
// key_prio_enc
// Combinational highest-index priority encoder.
// Ports:
//   i_ks   [N_KEYS-1:0]  synchronised key vector, 1 = pressed
//   o_enc  [CODE_W-1:0]  index of the highest set bit (0 when no bit is set)
//   o_none               1 when no bit of i_ks is set
module key_prio_enc #(
  parameter int N_KEYS = 10,
  parameter int CODE_W = 4
) (
  input  logic [N_KEYS-1:0] i_ks,
  output logic [CODE_W-1:0] o_enc,
  output logic              o_none
);

  always_comb begin
    // NOTE: assign every combinational output before any conditional so no
    // path leaves it unassigned; otherwise a latch is inferred.
    o_enc = '0;
    // Ascending scan: the last (highest) set bit wins.
    for (int i = 0; i < N_KEYS; i++) begin
      if (i_ks[i]) o_enc = CODE_W'(i);
    end
  end

  assign o_none = ~|i_ks;

endmodule

// File: rtl/keypad_debounce_encoder.sv
// keypad_debounce_encoder
// Synchronises and debounces a raw keypad vector (press and release), encodes
// the highest-index pressed key and emits one key_valid pulse per accepted
// press. Optional auto-repeat is compiled in with `define KEYPAD_REPEAT_EN.
// Ports:
//   clk        single clock
//   reset      synchronous, active-high reset
//   enablen    active-low enable; high forces the FSM to IDLE
//   keypad     [N_KEYS-1:0] raw asynchronous key lines, 1 = pressed
//   D          [CODE_W-1:0] code of the last accepted key
//   key_valid  one-cycle pulse per accepted press (and per repeat)
//   all_off    registered; 1 when the synchronised keypad vector is zero
module keypad_debounce_encoder
  import keypad_pkg::*;
#(
  parameter  int N_KEYS          = 10,
  parameter  int DEBOUNCE_CYCLES = 4,
  parameter  int REPEAT_DELAY    = 1000,
  parameter  int REPEAT_PERIOD   = 250,
  localparam int CODE_W          = code_width(N_KEYS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enablen,
  input  logic [N_KEYS-1:0] keypad,
  output logic [CODE_W-1:0] D,
  output logic              key_valid,
  output logic              all_off
);

  localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] r_sync1, r_ks;
  logic              r_all_off, r_kv;
  logic [CODE_W-1:0] r_d, r_cand;
  logic [CNT_W-1:0]  r_cnt;
  state_e            r_state;

  logic [CODE_W-1:0] w_enc, w_cand_nx, w_d_nx;
  logic              w_none, w_kv_nx;
  logic [CNT_W-1:0]  w_cnt_nx;
  state_e            w_state_nx;

`ifdef KEYPAD_REPEAT_EN
  // r_rep marks that the first repeat has fired, switching the target from
  // the initial hold delay to the repeat period.
  logic [CNT_W-1:0] r_rcnt, w_rcnt_nx, w_rep_target;
  logic             r_rep, w_rep_nx;
  assign w_rep_target = r_rep ? CNT_W'(REPEAT_PERIOD - 1) : CNT_W'(REPEAT_DELAY - 1);
`endif

  key_prio_enc #(
    .N_KEYS (N_KEYS),
    .CODE_W (CODE_W)
  ) u_prio_enc (
    .i_ks   (r_ks),
    .o_enc  (w_enc),
    .o_none (w_none)
  );

  always_comb begin
    w_state_nx = r_state;
    w_cand_nx  = r_cand;
    w_cnt_nx   = r_cnt;
    w_d_nx     = r_d;
    w_kv_nx    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    w_rcnt_nx  = r_rcnt;
    w_rep_nx   = r_rep;
`endif
    case (r_state)
      IDLE: begin
        if (!w_none) begin
          w_state_nx = DEBOUNCE;
          w_cand_nx  = w_enc;
          w_cnt_nx   = '0;
        end
      end
      DEBOUNCE: begin
        if (w_none) begin
          w_state_nx = IDLE;
        end else if (w_enc != r_cand) begin
          // A different key took priority: restart the stability window.
          w_cand_nx = w_enc;
          w_cnt_nx  = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nx = PRESSED;
          w_d_nx     = r_cand;
          w_kv_nx    = 1'b1;
`ifdef KEYPAD_REPEAT_EN
          w_rcnt_nx  = '0;
          w_rep_nx   = 1'b0;
`endif
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        // Key changes while held are ignored; everything must release first.
        if (w_none) begin
          w_state_nx = RELEASE;
          w_cnt_nx   = '0;
`ifdef KEYPAD_REPEAT_EN
          w_rcnt_nx  = '0;
          w_rep_nx   = 1'b0;
`endif
        end
`ifdef KEYPAD_REPEAT_EN
        else if (r_rcnt == w_rep_target) begin
          w_kv_nx   = 1'b1;
          w_d_nx    = w_enc;
          w_rcnt_nx = '0;
          w_rep_nx  = 1'b1;
        end else begin
          w_rcnt_nx = r_rcnt + CNT_W'(1);
        end
`endif
      end
      RELEASE: begin
        if (!w_none) begin
          // Release bounce: back to held without a new event.
          w_state_nx = PRESSED;
`ifdef KEYPAD_REPEAT_EN
          w_rcnt_nx  = '0;
          w_rep_nx   = 1'b0;
`endif
        end else if (r_cnt == DEB_LAST) begin
          w_state_nx = IDLE;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      r_sync1   <= '0;
      r_ks      <= '0;
      r_all_off <= 1'b1;
      r_state   <= IDLE;
      r_cand    <= '0;
      r_cnt     <= '0;
      r_d       <= '0;
      r_kv      <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rcnt    <= '0;
      r_rep     <= 1'b0;
`endif
    end else begin
      r_sync1   <= keypad;
      r_ks      <= r_sync1;
      r_all_off <= w_none;
      if (enablen) begin
        // Disabled: park in IDLE, keep D, keep the synchroniser running.
        r_state <= IDLE;
        r_cnt   <= '0;
        r_kv    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
        r_rcnt  <= '0;
        r_rep   <= 1'b0;
`endif
      end else begin
        r_state <= w_state_nx;
        r_cand  <= w_cand_nx;
        r_cnt   <= w_cnt_nx;
        r_d     <= w_d_nx;
        r_kv    <= w_kv_nx;
`ifdef KEYPAD_REPEAT_EN
        r_rcnt  <= w_rcnt_nx;
        r_rep   <= w_rep_nx;
`endif
      end
    end
  end

  assign D         = r_d;
  assign key_valid = r_kv;
  assign all_off   = r_all_off;

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// tb_keypad_debounce_encoder
// Self-checking bench: a behavioural model (stable-run lengths over the
// synchronised samples) is compared with the DUT on every cycle, and directed
// scenarios pin event latencies and codes with literal expectations.
module tb_keypad_debounce_encoder;

  localparam int NK  = 10;
  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enablen = 1'b0;
  logic [NK-1:0] keypad = '0;
  logic [3:0]    D;
  logic          key_valid;
  logic          all_off;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  keypad_debounce_encoder #(
    .N_KEYS          (NK),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enablen   (enablen),
    .keypad    (keypad),
    .D         (D),
    .key_valid (key_valid),
    .all_off   (all_off)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int enc_of(input logic [NK-1:0] v);
    int e = 0;
    for (int i = 0; i < NK; i++) if (v[i]) e = i;
    return e;
  endfunction

  // ---------------- behavioural model ----------------
  // seen = value the decision logic observes at an edge (raw input delayed by
  // two edges). A press is accepted when one nonzero code has been seen on
  // DEB+1 consecutive free, enabled edges; the hold ends after DEB+1
  // consecutive zero samples.
  logic [NK-1:0] m_s1 = '0, m_s2 = '0;
  bit            m_free = 1'b1;
  int            m_run = 0, m_code = 0, m_zrun = 0, m_since = 0;
  int            m_d = 0;
  bit            m_kv = 1'b0, m_all_off = 1'b1;

  always @(posedge clk) begin : model
    logic [NK-1:0] seen;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_free = 1'b1; m_run = 0; m_zrun = 0; m_since = 0;
      m_d = 0; m_kv = 1'b0; m_all_off = 1'b1;
    end else begin
      seen      = m_s2;
      m_all_off = (seen == '0);
      m_s2      = m_s1;
      m_s1      = keypad;
      m_kv      = 1'b0;
      if (enablen) begin
        m_free = 1'b1; m_run = 0;
      end else if (m_free) begin
        if (seen == '0) m_run = 0;
        else if (m_run > 0 && enc_of(seen) == m_code) m_run++;
        else begin m_run = 1; m_code = enc_of(seen); end
        if (m_run == DEB + 1) begin
          m_kv = 1'b1; m_d = m_code; m_free = 1'b0; m_zrun = 0; m_since = 0;
        end
      end else begin
        if (seen == '0) begin
          m_zrun++;
          if (m_zrun == DEB + 1) begin m_free = 1'b1; m_run = 0; end
        end else if (m_zrun > 0) begin
          m_zrun = 0; m_since = 0;
        end else begin
          m_since++;
`ifdef KEYPAD_REPEAT_EN
          if (m_since >= RD && (m_since - RD) % RP == 0) begin
            m_kv = 1'b1; m_d = enc_of(seen);
          end
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_key_valid", 32'(key_valid), 32'(m_kv));
      check("model_D",         32'(D),         32'(m_d));
      check("model_all_off",   32'(all_off),   32'(m_all_off));
    end
  end

  // ---------------- directed helpers ----------------
  // n = number of negedges waited until key_valid; event after edge k gives n=k+1.
  task automatic wait_kv(input int max_cycles, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!key_valid && n < max_cycles);
    check("kv_within_budget", 32'(key_valid), 32'd1);
  endtask

  task automatic count_kv(input int cycles, output int k);
    k = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (key_valid) k++;
    end
  endtask

  task automatic release_all();
    keypad = '0;
    repeat (12) @(negedge clk);
  endtask

  int n, k;

  initial begin
    // Reset held with key 9 pressed.
    @(negedge clk);
    cmp_en = 1'b1;
    keypad = 10'h200;
    repeat (3) begin
      @(negedge clk);
      check("rst_key_valid", 32'(key_valid), 32'd0);
      check("rst_all_off",   32'(all_off),   32'd1);
      check("rst_D",         32'(D),         32'd0);
    end
    reset = 1'b0;
    wait_kv(20, n);
    check("rst_release_latency", 32'(n - 1), 32'd6);
    check("rst_release_D", 32'(D), 32'd9);
    release_all();

    // Single stable press of key 5.
    keypad = 10'h020;
    wait_kv(20, n);
    check("press5_latency", 32'(n - 1), 32'd6);
    check("press5_D", 32'(D), 32'd5);
    count_kv(15, k);
    check("press5_no_more_events", 32'(k), 32'd0);
    release_all();

    // Bouncing key 3, then stable.
    for (int i = 0; i < 12; i++) begin
      keypad = (((i / 2) % 2) == 0) ? 10'h008 : 10'h000;
      @(negedge clk);
      if (key_valid) k++;
    end
    check("bounce_no_event", 32'(k), 32'd0);
    keypad = 10'h008;
    wait_kv(20, n);
    check("bounce_latency", 32'(n - 1), 32'd6);
    check("bounce_D", 32'(D), 32'd3);
    release_all();

    // Held key 2, add key 8: no new event until everything releases.
    keypad = 10'h004;
    wait_kv(20, n);
    check("hold2_D", 32'(D), 32'd2);
    keypad = 10'h104;
    count_kv(10, k);
    check("add_key_no_event", 32'(k), 32'd0);
    check("add_key_D_holds", 32'(D), 32'd2);
    keypad = 10'h000;
    repeat (10) @(negedge clk);
    keypad = 10'h100;
    wait_kv(20, n);
    check("press8_latency", 32'(n - 1), 32'd6);
    check("press8_D", 32'(D), 32'd8);
    release_all();

    // enablen during a debounce of key 1; fresh debounce after re-enable.
    keypad = 10'h002;
    repeat (3) @(negedge clk);
    enablen = 1'b1;
    count_kv(6, k);
    check("disabled_no_event", 32'(k), 32'd0);
    check("disabled_all_off", 32'(all_off), 32'd0);
    enablen = 1'b0;
    wait_kv(20, n);
    check("reenable_latency", 32'(n - 1), 32'(DEB));
    check("reenable_D", 32'(D), 32'd1);
    check("reenable_all_off", 32'(all_off), 32'd0);
    release_all();

    // Long hold of key 0.
    keypad = 10'h001;
    wait_kv(20, n);
    check("hold0_D", 32'(D), 32'd0);
    check("hold0_all_off", 32'(all_off), 32'd0);
`ifdef KEYPAD_REPEAT_EN
    wait_kv(40, n);
    check("repeat1_gap", 32'(n), 32'(RD));
    wait_kv(40, n);
    check("repeat2_gap", 32'(n), 32'(RP));
    wait_kv(40, n);
    check("repeat3_gap", 32'(n), 32'(RP));
    keypad = '0;
    count_kv(40, k);
    check("repeat_stops", 32'(k), 32'd0);
`else
    count_kv(40, k);
    check("no_repeat_when_held", 32'(k), 32'd0);
    keypad = '0;
`endif
    release_all();

    // Randomised traffic; the per-cycle compare checks against the model.
    for (int c = 0; c < 1500; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 12) begin
        case ($urandom_range(0, 3))
          0:       keypad = '0;
          1:       keypad = NK'(1) << $urandom_range(0, NK - 1);
          2:       keypad = NK'($urandom);
          default: keypad = keypad ^ (NK'(1) << $urandom_range(0, NK - 1));
        endcase
      end
      enablen = ($urandom_range(0, 59) == 0) ? ~enablen : enablen;
      reset   = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    enablen = 1'b0;
    keypad = '0;
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
